ped_request: RTL and testbench
==============================

# ped_request

Pedestrian walk-request front end that sits directly upstream of the traffic light sequencer. It synchronizes and debounces a raw push-button, then latches a single clean request that the sequencer services. The request is held until the sequencer acknowledges it. After the acknowledge, a cooldown window ignores further presses so repeated presses cannot keep extending the walk phase.

## Interface
- DEBOUNCE_CYCLES, 32'd1000000, consecutive cycles the synchronized input must differ from the stable level before the level flips (10 ms at 100 MHz); legal range is 1 and up.
- COOLDOWN_CYCLES, 32'd500000000, cycles after acknowledge during which presses are ignored (5 s at 100 MHz); 0 is treated as 1.
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- btn_raw  in  1  raw button, asynchronous to clk, active-high.
- ack  in  1  one-or-more-cycle acknowledge from sequencer; request serviced.
- req  out  1  latched walk request, level.
- btn_level  out  1  debounced button level.
- cooldown  out  1  high while in cooldown window.
- press_cnt  out  8  count of accepted requests, saturating at 255.

## Operation
- **Reset values:** req=0, btn_level=0, cooldown=0, press_cnt=0. Sync flops are 0, the debounce counter is 0, and the state is IDLE. Reset asserted mid-operation aborts any state immediately.
- **Synchronizer:** 2-flop chain on btn_raw.
- **Debounce counter (32-bit):**
  - While the synchronized value is not equal to btn_level, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the inputs still differ, btn_level toggles and the counter clears.
  - Any cycle in which the inputs are equal clears the counter.
  - Glitches shorter than DEBOUNCE_CYCLES therefore never reach btn_level.
- **Press event:** a one-cycle internal pulse on the btn_level 0→1 transition (btn_level & ~btn_level_q). Falling edges generate nothing.
- **FSM states:** IDLE, PENDING, COOLDOWN.
  - IDLE → PENDING on a press. press_cnt increments, saturating at 255.
  - PENDING → COOLDOWN on ack=1. Presses while PENDING are coalesced and not counted.
  - COOLDOWN → IDLE when the cooldown counter reaches max(COOLDOWN_CYCLES,1)-1. Presses are discarded and ack is ignored.
- **Outputs decoded from registered state:** req = (state==PENDING); cooldown = (state==COOLDOWN).
- **Simultaneous events:**
  - A press and ack in the same PENDING cycle: ack wins, the press is discarded, and the next state is COOLDOWN.
  - A press on the same cycle COOLDOWN expires is discarded.
  - ack while IDLE has no effect.
- **Width rules:** the counters are 32-bit unsigned with compare-equal, not ≥, against the parameter minus 1. press_cnt does not wrap.

## Timing
- A btn_raw step held steady, first sampled at edge 0, reaches btn_level at edge DEBOUNCE_CYCLES+2.
- req rises one edge after btn_level rises.
- Total latency from btn_raw to req is DEBOUNCE_CYCLES+3 edges.
- req falls on the first edge at which ack=1 is sampled while PENDING. cooldown rises on that same edge.
- cooldown stays high for exactly max(COOLDOWN_CYCLES,1) cycles, then drops, with the state back to IDLE.
- A press becomes acceptable the cycle after cooldown drops. Because btn_level must first fall and then rise again, a held button never re-triggers.
- req is never high while cooldown is high.

## Structure
- Shared package `ped_request_pkg` holds:
  - state encoding localparams: IDLE=2'd0, PENDING=2'd1, COOLDOWN=2'd2;
  - the press_cnt width (8).
- Sub-module `debounce_sync` contains the 2-flop synchronizer plus the debounce counter. It has parameter DEBOUNCE_CYCLES; ports clk, rst, din, and registered dout.
- The top level holds the edge detect, the FSM, the cooldown counter and press_cnt.
- The sequencer samples req and drives ack. No other handshake signals exist.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and COOLDOWN_CYCLES=8.
- **Reset:** assert rst mid-PENDING → req, cooldown, btn_level and press_cnt are 0 within the same cycle, asynchronously.
- **Clean press:** btn_raw 0→1, held for 20 cycles → btn_level rises at edge 6 and req rises at edge 7; press_cnt=1.
- **Bounce:** btn_raw pulses high for 3 cycles, low 2, high 3 → btn_level stays 0, req stays 0 and press_cnt stays 0.
- **Acknowledge and cooldown:** ack=1 one cycle while PENDING → req falls and cooldown rises on that edge. cooldown lasts exactly 8 cycles. A second clean press during cooldown is ignored, with press_cnt unchanged.
- **Simultaneous and held button:** a press pulse coinciding with ack → next state COOLDOWN, press_cnt unchanged. A button held through the whole cooldown never produces a second req.
- **Saturation:** 260 accepted press/ack cycles with COOLDOWN_CYCLES=0 → press_cnt stops at 255, and each cooldown lasts 1 cycle.

Source files
------------

// File: rtl/ped_request_pkg.sv
// ped_request_pkg
// Shared definitions for the pedestrian walk-request front end:
// the FSM state encoding and the width of the accepted-press counter.
// No ports; imported by ped_request.

package ped_request_pkg;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PENDING  = 2'd1;
    localparam logic [1:0] COOLDOWN = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = IDLE,
        ST_PENDING  = PENDING,
        ST_COOLDOWN = COOLDOWN
    } state_e;

    localparam int PRESS_CNT_W = 8;
    localparam logic [PRESS_CNT_W-1:0] PRESS_CNT_MAX = {PRESS_CNT_W{1'b1}};
    localparam logic [PRESS_CNT_W-1:0] PRESS_CNT_ONE = {{(PRESS_CNT_W-1){1'b0}}, 1'b1};

endpackage

// File: rtl/ped_request_debounce_sync.sv
// debounce_sync
// Brings an asynchronous push-button into the clk domain with a 2-flop
// synchronizer, then debounces it: the stable level only flips after the
// synchronized input has disagreed with it for DEBOUNCE_CYCLES consecutive
// cycles. The stable level is presented through one output register.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   din  - raw button, asynchronous to clk
//   dout - debounced, registered button level

module debounce_sync #(
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam logic [31:0] CNT_LAST = DEBOUNCE_CYCLES - 32'd1;

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        level_q, level_d;
    logic        dout_q,  dout_d;
    logic [31:0] cnt_q,   cnt_d;

    // Counter only runs while the synchronized input disagrees with the
    // stable level; any agreeing cycle restarts the count, so a glitch
    // shorter than DEBOUNCE_CYCLES can never flip the level.
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        dout_d  = level_q;
        level_d = level_q;
        cnt_d   = 32'd0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            dout_q  <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/ped_request.sv
// ped_request
// Pedestrian walk-request front end. Debounces the raw button, turns each
// debounced rising edge into a press, latches one request until the
// sequencer acknowledges it, then ignores presses for a cooldown window.
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-high reset
//   btn_raw   - raw button, asynchronous, active-high
//   ack       - acknowledge from the sequencer (request serviced)
//   req       - latched walk request
//   btn_level - debounced button level
//   cooldown  - high during the post-acknowledge cooldown window
//   press_cnt - accepted requests, saturating at 255

module ped_request
    import ped_request_pkg::*;
#(
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd1000000,
    parameter logic [31:0] COOLDOWN_CYCLES = 32'd500000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn_raw,
    input  logic                   ack,
    output logic                   req,
    output logic                   btn_level,
    output logic                   cooldown,
    output logic [PRESS_CNT_W-1:0] press_cnt
);

    // A zero cooldown still spends one cycle in COOLDOWN.
    localparam logic [31:0] COOL_LAST =
        (COOLDOWN_CYCLES == 32'd0) ? 32'd0 : (COOLDOWN_CYCLES - 32'd1);

    logic                   level;
    logic                   level_prev_q, level_prev_d;
    logic                   press;
    state_e                 state_q, state_d;
    logic [31:0]            cool_cnt_q, cool_cnt_d;
    logic [PRESS_CNT_W-1:0] press_cnt_q, press_cnt_d;

    debounce_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_raw),
        .dout (level)
    );

    // Rising edge of the debounced level only; releases are not events.
    always_comb begin
        level_prev_d = level;
        press        = level & ~level_prev_q;
    end

    // Next-state logic. In PENDING, ack takes priority over a coincident
    // press, and presses there are absorbed into the outstanding request.
    // COOLDOWN ignores both presses and ack until its counter expires.
    always_comb begin
        state_d     = state_q;
        cool_cnt_d  = cool_cnt_q;
        press_cnt_d = press_cnt_q;
        case (state_q)
            ST_IDLE: begin
                cool_cnt_d = 32'd0;
                if (press) begin
                    state_d = ST_PENDING;
                    if (press_cnt_q != PRESS_CNT_MAX) begin
                        press_cnt_d = press_cnt_q + PRESS_CNT_ONE;
                    end
                end
            end
            ST_PENDING: begin
                cool_cnt_d = 32'd0;
                if (ack) begin
                    state_d = ST_COOLDOWN;
                end
            end
            ST_COOLDOWN: begin
                if (cool_cnt_q == COOL_LAST) begin
                    state_d    = ST_IDLE;
                    cool_cnt_d = 32'd0;
                end else begin
                    cool_cnt_d = cool_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                cool_cnt_d = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_prev_q <= 1'b0;
            state_q      <= ST_IDLE;
            cool_cnt_q   <= 32'd0;
            press_cnt_q  <= '0;
        end else begin
            level_prev_q <= level_prev_d;
            state_q      <= state_d;
            cool_cnt_q   <= cool_cnt_d;
            press_cnt_q  <= press_cnt_d;
        end
    end

    assign req       = (state_q == ST_PENDING);
    assign cooldown  = (state_q == ST_COOLDOWN);
    assign btn_level = level;
    assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_ped_request.sv
// tb_ped_request
// Drives two ped_request instances (cooldown 8 and cooldown 0, debounce 4)
// and compares every output on every falling clock edge against a
// behavioural model, plus directed literal checks at known edges.

module tb_ped_request;

    localparam int DB   = 4;
    localparam int CD   = 8;
    localparam int CD0  = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_raw = 1'b0;
    logic       ack = 1'b0;
    logic       req, btn_level, cooldown;
    logic [7:0] press_cnt;

    logic       sat_raw = 1'b0;
    logic       sat_ack = 1'b0;
    logic       sat_req, sat_btn_level, sat_cooldown;
    logic [7:0] sat_press_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ped_request #(
        .DEBOUNCE_CYCLES(32'(DB)),
        .COOLDOWN_CYCLES(32'(CD))
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .ack       (ack),
        .req       (req),
        .btn_level (btn_level),
        .cooldown  (cooldown),
        .press_cnt (press_cnt)
    );

    ped_request #(
        .DEBOUNCE_CYCLES(32'(DB)),
        .COOLDOWN_CYCLES(32'(CD0))
    ) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (sat_raw),
        .ack       (sat_ack),
        .req       (sat_req),
        .btn_level (sat_btn_level),
        .cooldown  (sat_cooldown),
        .press_cnt (sat_press_cnt)
    );

    // Behavioural model: the button seen two samples late, a run length of
    // disagreeing samples that flips the stable level after DB in a row,
    // one cycle of output delay, and a request/cooldown with a countdown.
    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_COOL = 2;

    typedef struct packed {
        logic s1;
        logic s2;
        logic stable;
        logic lvl_out;
        logic lvl_prev;
        int   run;
        int   mode;
        int   cool_left;
        int   count;
    } mdl_t;

    mdl_t m_main, m_sat;

    function automatic mdl_t model_reset();
        mdl_t m;
        m = '0;
        return m;
    endfunction

    function automatic mdl_t model_step(input mdl_t m, input logic raw,
                                        input logic a, input int cool_len);
        mdl_t n;
        logic pressed;
        n = m;
        pressed = m.lvl_out && !m.lvl_prev;
        if (m.mode == M_IDLE) begin
            if (pressed) begin
                n.mode  = M_WAIT;
                n.count = (m.count < 255) ? m.count + 1 : 255;
            end
        end else if (m.mode == M_WAIT) begin
            if (a) begin
                n.mode      = M_COOL;
                n.cool_left = (cool_len < 1) ? 1 : cool_len;
            end
        end else begin
            n.cool_left = m.cool_left - 1;
            if (n.cool_left == 0) n.mode = M_IDLE;
        end
        n.lvl_prev = m.lvl_out;
        n.lvl_out  = m.stable;
        if (m.s2 != m.stable) begin
            n.run = m.run + 1;
            if (n.run == DB) begin
                n.stable = !m.stable;
                n.run    = 0;
            end
        end else begin
            n.run = 0;
        end
        n.s2 = m.s1;
        n.s1 = raw;
        return n;
    endfunction

    // Model advances on the same edges as the DUT and resets asynchronously.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_main = model_reset();
            m_sat  = model_reset();
        end else begin
            m_main = model_step(m_main, btn_raw, ack, CD);
            m_sat  = model_step(m_sat, sat_raw, sat_ack, CD0);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic raw, input logic a, input int cycles);
        btn_raw = raw;
        ack     = a;
        tick(cycles);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("main.req",       int'(req),           int'(m_main.mode == M_WAIT));
            checkOutput("main.cooldown",  int'(cooldown),      int'(m_main.mode == M_COOL));
            checkOutput("main.btn_level", int'(btn_level),     int'(m_main.lvl_out));
            checkOutput("main.press_cnt", int'(press_cnt),     m_main.count);
            checkOutput("main.req_vs_cd", int'(req & cooldown), 0);
            checkOutput("sat.req",        int'(sat_req),       int'(m_sat.mode == M_WAIT));
            checkOutput("sat.cooldown",   int'(sat_cooldown),  int'(m_sat.mode == M_COOL));
            checkOutput("sat.btn_level",  int'(sat_btn_level), int'(m_sat.lvl_out));
            checkOutput("sat.press_cnt",  int'(sat_press_cnt), m_sat.count);
        end
    end

    initial begin
        #1 rst = 1'b1;
        #1;
        checkOutput("reset.req",       int'(req),       0);
        checkOutput("reset.btn_level", int'(btn_level), 0);
        checkOutput("reset.cooldown",  int'(cooldown),  0);
        checkOutput("reset.press_cnt", int'(press_cnt), 0);
        tick(2);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 5);

        // Clean press: level at edge 6, request at edge 7.
        $display("[TB] clean press");
        applyStimulus(1'b1, 1'b0, 6);
        checkOutput("clean.level_e5", int'(btn_level), 0);
        tick(1);
        checkOutput("clean.level_e6", int'(btn_level), 1);
        checkOutput("clean.req_e6",   int'(req),       0);
        tick(1);
        checkOutput("clean.req_e7",   int'(req),       1);
        checkOutput("clean.cnt_e7",   int'(press_cnt), 1);
        tick(12);
        checkOutput("clean.req_held", int'(req),       1);

        // Acknowledge, then a held press that matures as cooldown expires.
        $display("[TB] ack and cooldown");
        applyStimulus(1'b0, 1'b0, 12);
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("ack.req",      int'(req),      0);
        checkOutput("ack.cooldown", int'(cooldown), 1);
        applyStimulus(1'b1, 1'b0, 7);
        checkOutput("ack.cd_last",  int'(cooldown), 1);
        tick(1);
        checkOutput("ack.cd_done",  int'(cooldown), 0);
        checkOutput("ack.req_after", int'(req),     0);
        tick(10);
        checkOutput("held.req",     int'(req),       0);
        checkOutput("held.cnt",     int'(press_cnt), 1);

        // Press pulse coinciding with ack while PENDING.
        $display("[TB] simultaneous press and ack");
        applyStimulus(1'b0, 1'b0, 12);
        applyStimulus(1'b1, 1'b0, 8);
        checkOutput("simul.req",  int'(req),       1);
        checkOutput("simul.cnt",  int'(press_cnt), 2);
        applyStimulus(1'b0, 1'b0, 10);
        applyStimulus(1'b1, 1'b0, 7);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("simul.cd",   int'(cooldown),  1);
        checkOutput("simul.req0", int'(req),       0);
        checkOutput("simul.cnt2", int'(press_cnt), 2);
        applyStimulus(1'b1, 1'b0, 15);
        applyStimulus(1'b0, 1'b0, 12);

        // Bounce: 3 high, 2 low, 3 high never reaches the level.
        $display("[TB] bounce");
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 2);
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 8);
        checkOutput("bounce.level", int'(btn_level), 0);
        checkOutput("bounce.req",   int'(req),       0);
        checkOutput("bounce.cnt",   int'(press_cnt), 2);

        // Random button activity and acknowledges.
        $display("[TB] random");
        for (int i = 0; i < 80; i++) begin
            int hold;
            logic r;
            hold = int'($urandom_range(1, 10));
            r    = logic'($urandom_range(0, 1));
            for (int j = 0; j < hold; j++) begin
                applyStimulus(r, logic'($urandom_range(0, 3) == 0), 1);
            end
        end

        // Reset asserted mid-PENDING clears everything asynchronously.
        $display("[TB] reset mid-pending");
        applyStimulus(1'b0, 1'b0, 20);
        applyStimulus(1'b1, 1'b0, 10);
        checkOutput("rst.pending", int'(req), 1);
        #3 rst = 1'b1;
        #1;
        checkOutput("rst.req",       int'(req),       0);
        checkOutput("rst.btn_level", int'(btn_level), 0);
        checkOutput("rst.cooldown",  int'(cooldown),  0);
        checkOutput("rst.press_cnt", int'(press_cnt), 0);
        btn_raw = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(3);

        // Saturation on the zero-cooldown instance.
        $display("[TB] saturation");
        sat_ack = 1'b1;
        for (int i = 0; i < 260; i++) begin
            sat_raw = 1'b1;
            tick(8);
            sat_raw = 1'b0;
            tick(8);
        end
        checkOutput("sat.final_cnt", int'(sat_press_cnt), 255);
        checkOutput("sat.final_cd",  int'(sat_cooldown),  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
